// File: rtl/nibble_serial_adder.sv
// Serial add/subtract sequencer: walks a WIDTH-bit operand pair through an
// external 4-bit ripple-carry adder one nibble per clock, least significant first.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   out_ovf,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_ci,
    input  logic [3:0]             add_s,
    input  logic                   add_co
);

    localparam int WIDTH = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic [WIDTH-1:0]   sum_d;

    // Select the active nibble; the adder is only driven (and its result only
    // merged into the sum) while the sequencer is running.
    always_comb begin
        add_a  = 4'h0;
        add_b  = 4'h0;
        add_ci = 1'b0;
        sum_d  = sum_q;
        if (state_q == S_RUN) begin
            add_ci = carry_q;
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    add_a           = a_q[4*i +: 4];
                    add_b           = b_q[4*i +: 4];
                    sum_d[4*i +: 4] = add_s;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B once, seed the carry.
                        a_q     <= in_a;
                        b_q     <= in_sub ? ~in_b : in_b;
                        carry_q <= in_sub;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= add_co;
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;
    assign out_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed vector table, random ops against an
// arithmetic reference, backpressure, mid-run reset and a single-nibble instance.
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, in_sub, out_valid, out_ready, out_cout, out_ovf;
    logic [W-1:0]  in_a, in_b, out_sum;
    logic [3:0]    add_a, add_b, add_s;
    logic          add_ci, add_co;

    logic          in_valid1, in_ready1, in_sub1, out_valid1, out_ready1, out_cout1, out_ovf1;
    logic [3:0]    in_a1, in_b1, out_sum1;
    logic [3:0]    add_a1, add_b1, add_s1;
    logic          add_ci1, add_co1;

    // External 4-bit ripple-carry adders, behavioural.
    assign {add_co, add_s}   = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};
    assign {add_co1, add_s1} = {1'b0, add_a1} + {1'b0, add_b1} + {4'b0, add_ci1};

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1), .in_sub(in_sub1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
        .out_cout(out_cout1), .out_ovf(out_ovf1),
        .add_a(add_a1), .add_b(add_b1), .add_ci(add_ci1), .add_s(add_s1), .add_co(add_co1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the whole word.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                  output logic [W-1:0] s, output logic co, output logic ovf,
                                  output logic [N-1:0] cis);
        int bb;
        int lo;
        int mask;
        if (sub) begin
            s   = a - b;
            co  = (a >= b);
            ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            s   = a + b;
            co  = ((int'(a) + int'(b)) >= 65536);
            ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
        bb = sub ? (int'(~b) & 32'hFFFF) : int'(b);
        for (int i = 0; i < N; i++) begin
            mask   = (1 << (4 * i)) - 1;
            lo     = (int'(a) & mask) + (bb & mask) + int'(sub);
            cis[i] = ((lo >> (4 * i)) != 0);
        end
    endfunction

    // Called at the negedge just after the accept edge, with in_valid already dropped.
    task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                               input string tag);
        logic [W-1:0] es;
        logic         eco, eov;
        logic [N-1:0] ecis;
        logic [N-1:0] cis;
        int k;
        model(a, b, sub, es, eco, eov, ecis);
        cis = '0;
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            if (k < N) cis[k] = add_ci;
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, k + 1, N + 1);
        chk({tag, "_sum"}, out_sum, es);
        chk({tag, "_cout"}, out_cout, eco);
        chk({tag, "_ovf"}, out_ovf, eov);
        chk({tag, "_ci_seq"}, cis, ecis);
        chk({tag, "_add_quiet"}, {add_a, add_b, add_ci}, 0);
        $display("op %s: 0x%04h %s 0x%04h -> sum 0x%04h cout %0d ovf %0d lat %0d",
                 tag, a, sub ? "-" : "+", b, out_sum, out_cout, out_ovf, k + 1);
    endtask

    // Hold the result for 'hold' cycles, then complete the handshake.
    task automatic release_out(input int hold, input string tag);
        logic [W-1:0] s0;
        s0 = out_sum;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_sum"}, out_sum, s0);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, out_valid, 0);
        chk({tag, "_post_in_ready"}, in_ready, 1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input int hold, input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(a, b, sub, tag);
        release_out(hold, tag);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } vec1_t;

    vec_t  vecs[5];
    vec1_t vecs1[3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs1[0] = '{4'h9, 4'h8, 1'b0, 4'h1, 1'b1, 1'b1};
        vecs1[1] = '{4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0};
        vecs1[2] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_sub1 = 1'b0; out_ready1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_cout_ovf", {out_cout, out_ovf}, 0);
        chk("rst_add", {add_a, add_b, add_ci}, 0);
        chk("rst1_ready_valid", {in_ready1, out_valid1}, 2'b10);
        rst_n = 1'b1;

        // Directed table: expected values come straight from the table.
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            chk("vec_in_ready", in_ready, 1);
            in_valid = 1'b1; in_a = vecs[v].a; in_b = vecs[v].b; in_sub = vecs[v].sub;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            wait_result(vecs[v].a, vecs[v].b, vecs[v].sub, "vec");
            chk("vec_tbl_sum", out_sum, vecs[v].sum);
            chk("vec_tbl_cout", out_cout, vecs[v].cout);
            chk("vec_tbl_ovf", out_ovf, vecs[v].ovf);
            release_out(0, "vec");
        end

        // Backpressure, with a second request waiting during the stall.
        @(negedge clk);
        in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(16'h1111, 16'h2222, 1'b0, "bp1");
        in_valid = 1'b1; in_a = 16'h00F0; in_b = 16'h0F0F; in_sub = 1'b1;
        release_out(10, "bp1");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp2_accepted", in_ready, 0);
        wait_result(16'h00F0, 16'h0F0F, 1'b1, "bp2");
        release_out(0, "bp2");

        // Random operations against the reference model.
        for (int r = 0; r < 40; r++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rnd");
        end

        // Reset while the third nibble is being processed.
        @(negedge clk);
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0FFF; in_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrun_nonzero_sum", (out_sum != 16'h0), 1);
        rst_n = 1'b0;
        #1;
        chk("midrun_in_ready", in_ready, 1);
        chk("midrun_out_valid", out_valid, 0);
        chk("midrun_out_sum", out_sum, 0);
        chk("midrun_cout_ovf", {out_cout, out_ovf}, 0);
        chk("midrun_add", {add_a, add_b, add_ci}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("after_rst_idle", {in_ready, out_valid}, 2'b10);
        end
        $display("op reset mid-run: aborted, block idle");

        // Single-nibble instance.
        for (int v = 0; v < 3; v++) begin
            int k;
            @(negedge clk);
            chk("n1_in_ready", in_ready1, 1);
            in_valid1 = 1'b1; in_a1 = vecs1[v].a; in_b1 = vecs1[v].b; in_sub1 = vecs1[v].sub;
            @(posedge clk);
            @(negedge clk);
            in_valid1 = 1'b0;
            k = 0;
            while (out_valid1 !== 1'b1 && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("n1_latency", k + 1, 2);
            chk("n1_sum", out_sum1, vecs1[v].sum);
            chk("n1_cout", out_cout1, vecs1[v].cout);
            chk("n1_ovf", out_ovf1, vecs1[v].ovf);
            $display("op n1: 0x%0h %s 0x%0h -> sum 0x%0h cout %0d ovf %0d lat %0d",
                     vecs1[v].a, vecs1[v].sub ? "-" : "+", vecs1[v].b, out_sum1, out_cout1, out_ovf1, k + 1);
            out_ready1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready1 = 1'b0;
            chk("n1_post", {in_ready1, out_valid1}, 2'b10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
